// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding buffer.
// Frame: start bit, DATA_BITS data bits (LSB first), optional parity bit,
// STOP_BITS stop bits. Every bit lasts exactly CLOCK_PER_BIT clock cycles.
// A word waiting in the buffer is loaded on the final stop edge, so frames
// can run back-to-back with no idle cycle between them.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | line idle high, waiting for the holding buffer to fill
// S_START  | driving the start bit (low)
// S_DATA   | shifting out data bits, LSB first
// S_PARITY | driving the parity bit computed when the word was loaded
// S_STOP   | driving stop bit(s) high; reload or return to idle at the end
module uart_tx_param #(
  parameter int CLOCK_PER_BIT = 40,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  if (CLOCK_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLOCK_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int CW = (CLOCK_PER_BIT > 1) ? $clog2(CLOCK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLOCK_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic                 full_q, full_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;
  logic                 load;
  logic                 par_bit;

  assign bit_end = (cnt_q == CNT_LAST);

  // Parity of the buffered word, captured into par_q when the word is loaded.
  always_comb begin
    par_bit = (PARITY == 1) ? ~^buf_q : ^buf_q;
  end

  // Next-state logic: buffer fill, bit timing, shifting and frame sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    full_d  = full_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    load    = 1'b0;

    // Accept only into an empty buffer; load only from a full one, so the
    // two never coincide on the same edge.
    if (i_valid && !full_q) begin
      full_d = 1'b1;
      buf_d  = i_data;
    end

    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (full_q) begin
          load = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            done_d = 1'b1;
            idx_d  = '0;
            if (full_q) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Moving the buffered word into the shifter starts a new frame at once.
    if (load) begin
      shift_d = buf_q;
      par_d   = par_bit;
      full_d  = 1'b0;
      state_d = S_START;
      cnt_d   = '0;
      idx_d   = '0;
      tx_d    = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any frame and empties the buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = ~full_q;
  assign o_tx    = tx_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five instances cover 8N1, 8E1, 8O1, 7N2 and a
// 9E1 minimum-timing configuration. Stimulus pushes the hand-written serial
// bit string of each frame into a queue; a monitor watches the active
// instance's line and compares each frame cycle by cycle against it.
module tb_uart_tx_param;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] valid;
  logic [N-1:0] tx;
  logic [N-1:0] ready;
  logic [N-1:0] busy;
  logic [N-1:0] done;
  logic [8:0]   data [N];

  int total = 0;
  int bad   = 0;
  int act_g = 0;
  int cyc   = 0;
  int done_cnt [N] = '{default: 0};

  typedef struct {
    string bits;
    int    cpb;
    bit    b2b;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          in_frame = 1'b0;
  bit          junk     = 1'b0;
  int          mcyc     = 0;
  int          flen     = 0;
  int          last_end = -10;
  logic [63:0] act_v;
  logic [63:0] exp_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int CPB = (g == 4) ? 2 : 4;
    localparam int DB  = (g == 3) ? 7 : ((g == 4) ? 9 : 8);
    localparam int PAR = (g == 1 || g == 4) ? 2 : ((g == 2) ? 1 : 0);
    localparam int SB  = (g == 3) ? 2 : 1;
    uart_tx_param #(
      .CLOCK_PER_BIT(CPB),
      .DATA_BITS    (DB),
      .PARITY       (PAR),
      .STOP_BITS    (SB)
    ) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_valid(valid[g]),
      .i_data (data[g][DB-1:0]),
      .o_ready(ready[g]),
      .o_tx   (tx[g]),
      .o_busy (busy[g]),
      .o_done (done[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic timeout(input string name, input int n);
    total++;
    bad++;
    $display("FAIL %s: no response within %0d cycles", name, n);
  endtask

  // Monitor: one frame per queue entry, sampled on the falling clock edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_frame = 1'b0;
      junk     = 1'b0;
    end else begin
      if (junk && tx[act_g]) junk = 1'b0;
      if (!in_frame && !junk && tx[act_g] == 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: line low at cycle %0d with no frame expected", cyc);
          junk = 1'b1;
        end else begin
          cur = exp_q.pop_front();
          if (cur.b2b) chk("b2b_gap", 64'(cyc - last_end - 1), 64'd0);
          flen  = cur.bits.len() * cur.cpb;
          mcyc  = 0;
          act_v = '0;
          exp_v = '0;
          for (int c = 0; c < flen; c++) exp_v[c] = (cur.bits[c / cur.cpb] == "1");
          in_frame = 1'b1;
        end
      end
      if (in_frame) begin
        act_v[mcyc] = tx[act_g];
        mcyc++;
        if (mcyc == flen) begin
          chk("frame_bits", act_v, exp_v);
          in_frame = 1'b0;
          last_end = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) if (rst_n && done[g]) done_cnt[g]++;
  end

  // Queue the expected frame, then hold i_valid until the word is accepted.
  task automatic send(input int g, input logic [8:0] d, input string bits,
                      input int cpb, input bit b2b, input bit keep);
    exp_t e;
    int   n;
    e.bits = bits;
    e.cpb  = cpb;
    e.b2b  = b2b;
    exp_q.push_back(e);
    @(negedge clk);
    valid[g] = 1'b1;
    data[g]  = d;
    n = 0;
    while (!ready[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("ready_wait", n);
    @(posedge clk);
    #1;
    if (!keep) valid[g] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("frames_drain", n);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, nd, nrdy, nbusy, nlow;
    rst_n = 1'b0;
    valid = '0;
    for (int g = 0; g < N; g++) data[g] = '0;
    #23;
    chk("rst_tx", 64'(tx), 64'h1F);
    chk("rst_ready", 64'(ready), 64'h1F);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8N1, single 0xA5, latency and frame length
    act_g = 0;
    send(0, 9'h0A5, "0101001011", 4, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_tx_hold", 64'(tx[0]), 64'd1);
    chk("lat_ready_low", 64'(ready[0]), 64'd0);
    @(negedge clk);
    chk("lat_tx_fall", 64'(tx[0]), 64'd0);
    chk("lat_ready_high", 64'(ready[0]), 64'd1);
    chk("lat_busy", 64'(busy[0]), 64'd1);
    n = 0;
    while (!done[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("done_wait", n);
    chk("frame_len_8n1", 64'(n), 64'd40);
    chk("done_busy_drop", 64'(busy[0]), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done[0]), 64'd0);
    wait_idle();
    chk("done_cnt_8n1", 64'(done_cnt[0]), 64'd1);

    // 8E1 then 8O1 with 0xA5 and 0x07
    act_g = 1;
    send(1, 9'h0A5, "01010010101", 4, 1'b0, 1'b0);
    send(1, 9'h007, "01110000011", 4, 1'b1, 1'b0);
    wait_idle();
    chk("done_cnt_8e1", 64'(done_cnt[1]), 64'd2);
    act_g = 2;
    send(2, 9'h0A5, "01010010111", 4, 1'b0, 1'b0);
    send(2, 9'h007, "01110000001", 4, 1'b1, 1'b0);
    wait_idle();
    chk("done_cnt_8o1", 64'(done_cnt[2]), 64'd2);

    // 7N2, bit 7 of the bus is set but not part of the frame
    act_g = 3;
    send(3, 9'h0D5, "0101010111", 4, 1'b0, 1'b0);
    wait_idle();
    chk("done_cnt_7n2", 64'(done_cnt[3]), 64'd1);

    // back-to-back with i_valid held high
    act_g = 0;
    fork
      begin
        send(0, 9'h001, "0100000001", 4, 1'b0, 1'b1);
        send(0, 9'h002, "0010000001", 4, 1'b1, 1'b1);
        send(0, 9'h003, "0110000001", 4, 1'b1, 1'b0);
      end
      begin
        n = 0;
        while (tx[0] && n < 20) begin
          @(negedge clk);
          n++;
        end
        if (n >= 20) timeout("b2b_start_wait", n);
        nd = 0;
        nrdy = 0;
        nbusy = 0;
        for (int i = 1; i <= 300; i++) begin
          @(negedge clk);
          if (done[0]) nd++;
          if (nd == 3) break;
          if (i < 40 && ready[0]) nrdy++;
          if (i == 40) begin
            chk("b2b_ready_at_load", 64'(ready[0]), 64'd1);
            chk("b2b_start2_low", 64'(tx[0]), 64'd0);
          end
          if (!busy[0]) nbusy++;
        end
        chk("b2b_done_pulses", 64'(nd), 64'd3);
        chk("b2b_ready_low", 64'(nrdy), 64'd0);
        chk("b2b_busy_low", 64'(nbusy), 64'd0);
      end
    join
    wait_idle();
    chk("done_cnt_b2b", 64'(done_cnt[0]), 64'd4);

    // reset during data bit 3 with the buffer full
    send(0, 9'h05A, "0010110101", 4, 1'b0, 1'b0);
    n = 0;
    while (tx[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("rst_start_wait", n);
    send(0, 9'h0FF, "0111111111", 4, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_buf_full", 64'(ready[0]), 64'd0);
    repeat (15) @(negedge clk);
    chk("rst_mid_frame_busy", 64'(busy[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", 64'(tx[0]), 64'd1);
    chk("arst_ready", 64'(ready[0]), 64'd1);
    chk("arst_busy", 64'(busy[0]), 64'd0);
    chk("arst_done", 64'(done[0]), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nlow = 0;
    repeat (60) begin
      @(negedge clk);
      if (!tx[0] || !ready[0] || busy[0]) nlow++;
    end
    chk("post_rst_idle", 64'(nlow), 64'd0);
    chk("done_cnt_rst", 64'(done_cnt[0]), 64'd4);

    // 9E1 at two clocks per bit
    act_g = 4;
    send(4, 9'h1FF, "011111111111", 2, 1'b0, 1'b0);
    send(4, 9'h100, "000000000111", 2, 1'b1, 1'b0);
    wait_idle();
    chk("done_cnt_9e1", 64'(done_cnt[4]), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
